pdp8_ttin: RTL and testbench

PDP8_TTIN -- requirements
Module: pdp8_ttin

---
 rtl/pdp8_pkg.sv | 32 +++
 rtl/pdp8_uart_rx.sv | 168 ++++++++++++++++
 rtl/pdp8_ttin.sv | 99 +++++++++
 tb/tb_pdp8_ttin.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: major-state codes, IOT device codes and the
// serial receiver state encoding used by the console keyboard interface.
package pdp8_pkg;

    localparam logic [3:0] F0 = 4'd0;
    localparam logic [3:0] F1 = 4'd1;
    localparam logic [3:0] F2 = 4'd2;
    localparam logic [3:0] F3 = 4'd3;

    localparam logic [5:0] DEV_TTIN  = 6'o03;
    localparam logic [5:0] DEV_TTOUT = 6'o04;

    // Oversample ticks within one bit: sample the start bit mid-way, then
    // every full bit time after that.
    localparam logic [3:0] TICK_START_MID = 4'd7;
    localparam logic [3:0] TICK_BIT_LAST  = 4'd15;
    localparam logic [2:0] DATA_BIT_LAST  = 3'd7;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    // Odd-one-out check on a 12-bit word; handy for bus sanity monitors.
    function automatic logic word_parity(input logic [11:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/pdp8_uart_rx.sv
// 8N1 asynchronous receiver: two-flop synchronizer, oversample divider
// (restarted on start detect) and IDLE/START/DATA/STOP/BREAK sequencer.
module pdp8_uart_rx #(
    parameter int CLK_DIV = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid
);
    import pdp8_pkg::*;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    logic [DIV_W-1:0] div_r;
    rx_state_e        state_r;
    rx_state_e        state_next;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_next;
    logic [2:0]       bit_r;
    logic [2:0]       bit_next;
    logic [7:0]       shift_r;
    logic [7:0]       shift_next;
    logic             tick_s;
    logic             fall_s;
    logic             restart_s;
    logic             valid_s;

    assign tick_s = (div_r == DIV_LAST);
    assign fall_s = rx_prev_r & ~rx_sync_r;
    assign data   = shift_r;
    assign valid  = valid_s;

    // Bring the asynchronous line into the clk domain; rx_prev_r feeds edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rxd;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Free-running oversample divider, re-phased to the start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= '0;
        end else if (restart_s) begin
            div_r <= '0;
        end else if (div_r == DIV_LAST) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RX_IDLE;
            cnt_r   <= 4'd0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            state_r <= state_next;
            cnt_r   <= cnt_next;
            bit_r   <= bit_next;
            shift_r <= shift_next;
        end
    end

    // Next-state logic; valid_s pulses in the tick cycle of a good stop bit.
    always_comb begin
        state_next = state_r;
        cnt_next   = cnt_r;
        bit_next   = bit_r;
        shift_next = shift_r;
        valid_s    = 1'b0;
        restart_s  = 1'b0;
        case (state_r)
            RX_IDLE: begin
                if (fall_s) begin
                    state_next = RX_START;
                    cnt_next   = 4'd0;
                    restart_s  = 1'b1;
                end else begin
                    state_next = RX_IDLE;
                end
            end
            RX_START: begin
                if (tick_s) begin
                    if (cnt_r == TICK_START_MID) begin
                        cnt_next   = 4'd0;
                        bit_next   = 3'd0;
                        state_next = rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_next = cnt_r + 4'd1;
                    end
                end else begin
                    cnt_next = cnt_r;
                end
            end
            RX_DATA: begin
                if (tick_s) begin
                    if (cnt_r == TICK_BIT_LAST) begin
                        cnt_next   = 4'd0;
                        shift_next = {rx_sync_r, shift_r[7:1]};
                        if (bit_r == DATA_BIT_LAST) begin
                            state_next = RX_STOP;
                        end else begin
                            bit_next = bit_r + 3'd1;
                        end
                    end else begin
                        cnt_next = cnt_r + 4'd1;
                    end
                end else begin
                    cnt_next = cnt_r;
                end
            end
            RX_STOP: begin
                if (tick_s) begin
                    if (cnt_r == TICK_BIT_LAST) begin
                        cnt_next = 4'd0;
                        if (rx_sync_r) begin
                            valid_s    = 1'b1;
                            state_next = RX_IDLE;
                        end else begin
                            state_next = RX_BREAK;
                        end
                    end else begin
                        cnt_next = cnt_r + 4'd1;
                    end
                end else begin
                    cnt_next = cnt_r;
                end
            end
            RX_BREAK: begin
                // Counts consecutive high ticks; any low tick restarts the bit time.
                if (tick_s) begin
                    if (!rx_sync_r) begin
                        cnt_next = 4'd0;
                    end else if (cnt_r == TICK_BIT_LAST) begin
                        cnt_next   = 4'd0;
                        state_next = RX_IDLE;
                    end else begin
                        cnt_next = cnt_r + 4'd1;
                    end
                end else begin
                    cnt_next = cnt_r;
                end
            end
            default: begin
                state_next = RX_IDLE;
                cnt_next   = 4'd0;
                bit_next   = 3'd0;
            end
        endcase
    end

endmodule

// File: rtl/pdp8_ttin.sv
// PDP-8 console keyboard (device 03): flag, receive buffer and IOT decode.
// Build option PDP8_TTIN_MARK_PARITY_EN forces bit 7 of each loaded character to 1.
module pdp8_ttin #(
    parameter int CLK_DIV = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iot,
    input  logic [3:0]  state,
    input  logic [11:0] mb,
    input  logic [5:0]  io_select,
    input  logic [11:0] io_data_in,
    output logic [11:0] io_data_out,
    output logic        io_selected,
    output logic        io_data_avail,
    output logic        io_interrupt,
    output logic        io_skip,
    input  logic        rxd
);
    import pdp8_pkg::*;

    logic [7:0]  rx_data_s;
    logic        rx_valid_s;
    logic [7:0]  rx_load_s;
    logic [7:0]  rx_buf_r;
    logic        flag_r;
    logic        selected_s;
    logic        clear_s;
    logic [11:0] ac_term_s;
    logic        unused_mb;

    assign unused_mb = ^mb[11:3];

    pdp8_uart_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .data  (rx_data_s),
        .valid (rx_valid_s)
    );

`ifdef PDP8_TTIN_MARK_PARITY_EN
    logic unused_parity;
    assign unused_parity = rx_data_s[7];
    assign rx_load_s     = {1'b1, rx_data_s[6:0]};
`else
    assign rx_load_s = rx_data_s;
`endif

    assign selected_s = ~reset & iot & (state == F1) & (io_select == DEV_TTIN);
    assign clear_s    = selected_s & mb[1];
    assign ac_term_s  = clear_s ? 12'o0000 : io_data_in;

    // IOT response is combinational within the F1 cycle.
    always_comb begin
        io_selected = 1'b0;
        io_skip     = 1'b0;
        io_data_out = io_data_in;
        if (selected_s) begin
            io_selected = 1'b1;
            io_skip     = mb[0] & flag_r;
            io_data_out = mb[2] ? (ac_term_s | {4'b0000, rx_buf_r}) : ac_term_s;
        end else begin
            io_selected = 1'b0;
            io_skip     = 1'b0;
            io_data_out = io_data_in;
        end
    end

    // Receive buffer; an unread character is simply overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_buf_r <= 8'h00;
        end else if (rx_valid_s) begin
            rx_buf_r <= rx_load_s;
        end else begin
            rx_buf_r <= rx_buf_r;
        end
    end

    // Keyboard flag: a completing character wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_r <= 1'b0;
        end else if (rx_valid_s) begin
            flag_r <= 1'b1;
        end else if (clear_s) begin
            flag_r <= 1'b0;
        end else begin
            flag_r <= flag_r;
        end
    end

    assign io_interrupt  = flag_r;
    assign io_data_avail = 1'b1;

endmodule

// File: tb/tb_pdp8_ttin.sv
// Directed bench for pdp8_ttin: serial frames on rxd, IOT commands on the bus,
// expected characters queued at send time and checked when the flag rises.
module tb_pdp8_ttin;
    import pdp8_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int BIT_CLKS = 16 * CLK_DIV;
    // Edges from the start-bit drive to the stop-bit sample edge:
    // 3 (sync + detect) + 4 * 152 ticks.
    localparam int STOP_EDGE = 611;

    logic        clk = 1'b0;
    logic        reset;
    logic        iot;
    logic [3:0]  state;
    logic [11:0] mb;
    logic [5:0]  io_select;
    logic [11:0] io_data_in;
    logic [11:0] io_data_out;
    logic        io_selected;
    logic        io_data_avail;
    logic        io_interrupt;
    logic        io_skip;
    logic        rxd;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    pdp8_ttin #(.CLK_DIV(CLK_DIV)) dut (
        .clk           (clk),
        .reset         (reset),
        .iot           (iot),
        .state         (state),
        .mb            (mb),
        .io_select     (io_select),
        .io_data_in    (io_data_in),
        .io_data_out   (io_data_out),
        .io_selected   (io_selected),
        .io_data_avail (io_data_avail),
        .io_interrupt  (io_interrupt),
        .io_skip       (io_skip),
        .rxd           (rxd)
    );

    function automatic logic [7:0] rx_expect(input logic [7:0] b);
`ifdef PDP8_TTIN_MARK_PARITY_EN
        return b | 8'h80;
`else
        return b;
`endif
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%04o expected=%04o", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        iot        = 1'b0;
        state      = F0;
        io_select  = 6'o00;
        mb         = 12'o0000;
        io_data_in = 12'o0000;
    endtask

    task automatic bus_cmd(input logic [11:0] m, input logic [11:0] d);
        iot        = 1'b1;
        state      = F1;
        io_select  = DEV_TTIN;
        mb         = m;
        io_data_in = d;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_char);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        if (expect_char) exp_q.push_back(rx_expect(b));
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_pop(output logic [7:0] v);
        check("sb_depth", {11'b0, (exp_q.size() != 0)}, 12'd1);
        if (exp_q.size() != 0) v = exp_q.pop_front();
        else v = 8'h00;
    endtask

    initial begin
        logic [7:0] exp_b;
        logic [7:0] last_rx;

        reset = 1'b1;
        rxd   = 1'b1;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        io_data_in = 12'o1234;
        #1;
        check("rst_intr", {11'b0, io_interrupt}, 12'd0);
        check("rst_pass", io_data_out, 12'o1234);
        check("rst_avail", {11'b0, io_data_avail}, 12'd1);
        bus_cmd(12'o6031, 12'o0000);
        #1;
        check("rst_sel", {11'b0, io_selected}, 12'd0);
        check("rst_skip", {11'b0, io_skip}, 12'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        bus_cmd(12'o6034, 12'o0000);
        #1;
        check("krs_sel", {11'b0, io_selected}, 12'd1);
        check("krs_rst_buf", io_data_out, 12'o0000);
        check("krs_noskip", {11'b0, io_skip}, 12'd0);
        bus_idle();

        // Single character with exact flag timing.
        @(posedge clk);
        #1;
        fork
            send_frame(8'h41, 1'b1, 1'b1);
        join_none
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1;
        check("flag_early", {11'b0, io_interrupt}, 12'd0);
        @(posedge clk);
        #1;
        check("flag_set", {11'b0, io_interrupt}, 12'd1);
        bus_cmd(12'o6031, 12'o0000);
        #1;
        check("ksf_skip", {11'b0, io_skip}, 12'd1);
        sb_pop(exp_b);
        bus_cmd(12'o6034, 12'o7000);
        #1;
        check("krs_or", io_data_out, 12'o7000 | {4'b0000, exp_b});
        @(posedge clk);
        #1;
        check("krs_keeps", {11'b0, io_interrupt}, 12'd1);

        // Commands that must not be decoded as ours.
        io_select  = DEV_TTOUT;
        mb         = 12'o6036;
        io_data_in = 12'o1234;
        #1;
        check("odev_sel", {11'b0, io_selected}, 12'd0);
        check("odev_pass", io_data_out, 12'o1234);
        @(posedge clk);
        #1;
        check("odev_flag", {11'b0, io_interrupt}, 12'd1);
        io_select = DEV_TTIN;
        state     = F2;
        #1;
        check("f2_sel", {11'b0, io_selected}, 12'd0);
        @(posedge clk);
        #1;
        check("f2_flag", {11'b0, io_interrupt}, 12'd1);
        state = F1;
        iot   = 1'b0;
        #1;
        check("noiot_sel", {11'b0, io_selected}, 12'd0);
        @(posedge clk);
        #1;
        check("noiot_flag", {11'b0, io_interrupt}, 12'd1);

        bus_cmd(12'o6036, 12'o7777);
        #1;
        check("krb_data", io_data_out, {4'b0000, exp_b});
        @(posedge clk);
        #1;
        bus_cmd(12'o6031, 12'o0000);
        #1;
        check("krb_clears", {11'b0, io_interrupt}, 12'd0);
        check("ksf_noskip", {11'b0, io_skip}, 12'd0);
        bus_idle();
        last_rx = exp_b;
        repeat (40) @(posedge clk);
        #1;

        // Start-bit glitch of 4 ticks is rejected.
        rxd = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1;
        check("glitch_flag", {11'b0, io_interrupt}, 12'd0);

        // Framing error, then a short high pulse that must not leave BREAK.
        @(posedge clk);
        #1;
        fork
            send_frame(8'h55, 1'b0, 1'b0);
        join_none
        repeat (STOP_EDGE + 2) @(posedge clk);
        #1;
        check("ferr_flag", {11'b0, io_interrupt}, 12'd0);
        repeat (10 * BIT_CLKS + BIT_CLKS - STOP_EDGE - 2) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
        rxd = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (12 * BIT_CLKS) @(posedge clk);
        #1;
        check("break_flag", {11'b0, io_interrupt}, 12'd0);
        bus_cmd(12'o6034, 12'o0000);
        #1;
        check("ferr_buf", io_data_out, {4'b0000, last_rx});
        @(posedge clk);
        #1;
        bus_idle();

        // Back-to-back characters, no read; KCC lands on the second stop sample.
        @(posedge clk);
        #1;
        fork
            begin
                send_frame(8'h31, 1'b1, 1'b1);
                send_frame(8'h32, 1'b1, 1'b1);
            end
        join_none
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1;
        check("c1_early", {11'b0, io_interrupt}, 12'd0);
        @(posedge clk);
        #1;
        check("c1_flag", {11'b0, io_interrupt}, 12'd1);
        sb_pop(exp_b);
        bus_cmd(12'o6034, 12'o0000);
        #1;
        check("c1_buf", io_data_out, {4'b0000, exp_b});
        bus_idle();
        repeat (10 * BIT_CLKS - 1) @(posedge clk);
        #1;
        bus_cmd(12'o6032, 12'o0000);
        #1;
        check("ovr_pre_flag", {11'b0, io_interrupt}, 12'd1);
        @(posedge clk);
        #1;
        bus_idle();
        check("kcc_vs_set", {11'b0, io_interrupt}, 12'd1);
        sb_pop(exp_b);
        bus_cmd(12'o6034, 12'o0000);
        #1;
        check("ovr_buf", io_data_out, {4'b0000, exp_b});
        bus_idle();
        repeat (40) @(posedge clk);
        #1;

        // Reset during the data bits abandons the frame.
        fork
            send_frame(8'h41, 1'b1, 1'b0);
        join_none
        repeat (4 * BIT_CLKS) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (7 * BIT_CLKS) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_flag", {11'b0, io_interrupt}, 12'd0);
        bus_cmd(12'o6034, 12'o0000);
        #1;
        check("mid_rst_buf", io_data_out, 12'o0000);
        bus_idle();
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1;
        check("mid_rst_late", {11'b0, io_interrupt}, 12'd0);
        check("sb_drained", exp_q.size(), 12'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
